memory_bus: RTL and testbench

- Parametrised multi-master memory bus controller; successor to the hard-wired CPU/ROM/RAM address mux in the computer top level.
- Arbitrates M masters (CPU, VDP DMA, future blitter) onto one shared slave bus.
- Decodes the top address bits into REGIONS chip-selects and inserts per-region wait states.
- Blocks writes to protected (ROM) regions, acknowledging them with a fault pulse.

---
 rtl/bus_pkg.sv | 9 +
 rtl/rr_arbiter.sv | 22 ++
 rtl/memory_bus.sv | 105 ++++++++++
 tb/tb_memory_bus.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// bus_pkg: shared FSM encoding, bus widths and the address-to-region decode helper.
package bus_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;
  localparam int BUS_ADDR_W = 16;
  localparam int BUS_DATA_W = 8;
  function automatic int unsigned region_of(logic [BUS_ADDR_W-1:0] addr, int unsigned rbits);
    return 32'(addr >> (BUS_ADDR_W - rbits));
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, scanning upward from last+1 with wrap.
module rr_arbiter #(
  parameter int MASTERS = 2,
  parameter int IW = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
  input  logic [MASTERS-1:0] req_i,
  input  logic [IW-1:0]      last_i,
  output logic [IW-1:0]      grant_o,
  output logic               valid_o
);
  // Walk the ring backwards so the nearest requester after last wins the final assignment.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    for (int k = MASTERS; k >= 1; k--) begin
      if (req_i[(int'(last_i) + k) % MASTERS]) begin
        grant_o = IW'((int'(last_i) + k) % MASTERS);
        valid_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/memory_bus.sv
// memory_bus: multi-master arbiter onto one slave bus with region decode,
// per-region wait states and write protection with a saturating fault counter.
module memory_bus
  import bus_pkg::*;
#(
  parameter int MASTERS = 2,
  parameter int REGION_BITS = 2,
  parameter logic [4*(2**REGION_BITS)-1:0] WAIT_STATES = 16'h2100,
  parameter logic [(2**REGION_BITS)-1:0] WP_MASK = 4'b0001
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [MASTERS-1:0]                  m_req_i,
  input  logic [MASTERS-1:0]                  m_we_i,
  input  logic [BUS_ADDR_W*MASTERS-1:0]       m_addr_i,
  input  logic [BUS_DATA_W*MASTERS-1:0]       m_wdata_i,
  output logic [MASTERS-1:0]                  m_ack_o,
  output logic [BUS_DATA_W-1:0]               m_rdata_o,
  output logic [(2**REGION_BITS)-1:0]         s_cs_o,
  output logic                                s_we_o,
  output logic [BUS_ADDR_W-1:0]               s_addr_o,
  output logic [BUS_DATA_W-1:0]               s_wdata_o,
  input  logic [BUS_DATA_W*(2**REGION_BITS)-1:0] s_rdata_i,
  output logic                                write_fault_o,
  output logic [7:0]                          fault_count_o
);
  localparam int IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int REGIONS = 2**REGION_BITS;
  state_t                  state_q;
  logic [IW-1:0]           gnt, gnt_q, last_q;
  logic                    vld;
  logic [BUS_ADDR_W-1:0]   g_addr, addr_q;
  logic [REGION_BITS-1:0]  g_region, region_q;
  logic                    we_q, s_we_q, fault_q;
  logic [3:0]              cnt_q;
  logic [MASTERS-1:0]      ack_q;
  logic [BUS_DATA_W-1:0]   rdata_q, wdata_q;
  logic [REGIONS-1:0]      cs_q;
  logic [7:0]              fcnt_q;
  rr_arbiter #(.MASTERS(MASTERS), .IW(IW)) u_arb (
    .req_i   (m_req_i),
    .last_i  (last_q),
    .grant_o (gnt),
    .valid_o (vld)
  );
  assign g_addr   = m_addr_i[BUS_ADDR_W*int'(gnt) +: BUS_ADDR_W];
  assign g_region = REGION_BITS'(region_of(g_addr, REGION_BITS));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      last_q   <= IW'(MASTERS - 1);
      region_q <= '0;
      we_q     <= 1'b0;
      cnt_q    <= '0;
      ack_q    <= '0;
      rdata_q  <= '0;
      cs_q     <= '0;
      s_we_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      fault_q  <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (vld) begin
          state_q  <= ACCESS;
          gnt_q    <= gnt;
          last_q   <= gnt;
          region_q <= g_region;
          we_q     <= m_we_i[gnt];
          cnt_q    <= WAIT_STATES[4*int'(g_region) +: 4];
          addr_q   <= g_addr;
          wdata_q  <= m_wdata_i[BUS_DATA_W*int'(gnt) +: BUS_DATA_W];
          cs_q     <= REGIONS'(1) << g_region;
          s_we_q   <= m_we_i[gnt] & ~WP_MASK[g_region];
        end
        ACCESS: if (cnt_q == 4'd0) begin
          state_q       <= DONE;
          cs_q          <= '0;
          s_we_q        <= 1'b0;
          ack_q[gnt_q]  <= 1'b1;
          fault_q       <= we_q & WP_MASK[region_q];
          if (!we_q) rdata_q <= s_rdata_i[BUS_DATA_W*int'(region_q) +: BUS_DATA_W];
          if (we_q && WP_MASK[region_q] && fcnt_q != 8'hFF) fcnt_q <= fcnt_q + 8'd1;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
        default: begin
          state_q <= IDLE;
          ack_q   <= '0;
          fault_q <= 1'b0;
        end
      endcase
    end
  end
  assign m_ack_o       = ack_q;
  assign m_rdata_o     = rdata_q;
  assign s_cs_o        = cs_q;
  assign s_we_o        = s_we_q;
  assign s_addr_o      = addr_q;
  assign s_wdata_o     = wdata_q;
  assign write_fault_o = fault_q;
  assign fault_count_o = fcnt_q;
endmodule

// File: tb/tb_memory_bus.sv
// tb_memory_bus: directed checks of arbitration, decode, wait states, protection and reset abort.
module tb_memory_bus;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  m_req, m_we, m_ack;
  logic [31:0] m_addr;
  logic [15:0] m_wdata;
  logic [7:0]  m_rdata, s_wdata, fault_count;
  logic [3:0]  s_cs;
  logic        s_we, write_fault;
  logic [15:0] s_addr;
  logic [31:0] s_rdata;
  int n_assert = 0;
  int n_fail = 0;
  int lat, csc, wec;
  logic [3:0] css;
  logic flt;

  memory_bus dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .m_req_i       (m_req),
    .m_we_i        (m_we),
    .m_addr_i      (m_addr),
    .m_wdata_i     (m_wdata),
    .m_ack_o       (m_ack),
    .m_rdata_o     (m_rdata),
    .s_cs_o        (s_cs),
    .s_we_o        (s_we),
    .s_addr_o      (s_addr),
    .s_wdata_o     (s_wdata),
    .s_rdata_i     (s_rdata),
    .write_fault_o (write_fault),
    .fault_count_o (fault_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Single-master transfer started in an IDLE cycle; returns ack latency and slave-side activity.
  task automatic run(input int m, input logic we, input logic [15:0] addr, input logic [7:0] wd,
                     output int l, output int cs_n, output logic [3:0] cs_s, output int we_n,
                     output logic f);
    l = -1; cs_n = 0; cs_s = '0; we_n = 0; f = 1'b0;
    m_we[m] = we;
    m_addr[16*m +: 16] = addr;
    m_wdata[8*m +: 8] = wd;
    m_req[m] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (s_cs != 4'b0) begin cs_n++; cs_s |= s_cs; end
      if (s_we) we_n++;
      if (m_ack[m]) begin l = i; f = write_fault; break; end
    end
    m_req[m] = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    m_req = 2'b11;
    m_we = 2'b00;
    m_addr = {16'h4000, 16'h0123};
    m_wdata = 16'h0;
    s_rdata = {8'hD3, 8'hC2, 8'hB1, 8'hA5};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", m_ack, 2'b00);
    chk("rst_cs", s_cs, 4'b0000);
    chk("rst_we", s_we, 1'b0);
    chk("rst_fault", write_fault, 1'b0);
    chk("rst_fcnt", fault_count, 8'd0);
    chk("rst_rdata", m_rdata, 8'd0);
    chk("rst_addr", s_addr, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("r0_noack_idle", m_ack, 2'b00);
    @(posedge clk); #1;
    chk("r0_cs", s_cs, 4'b0001);
    chk("r0_addr_m0_first", s_addr, 16'h0123);
    chk("r0_we", s_we, 1'b0);
    m_req = 2'b01;
    @(posedge clk); #1;
    chk("r0_ack", m_ack, 2'b01);
    chk("r0_rdata", m_rdata, 8'hA5);
    chk("r0_cs_done", s_cs, 4'b0000);
    m_req = 2'b00;
    @(posedge clk); #1;

    run(0, 1'b1, 16'hC000, 8'h5A, lat, csc, css, wec, flt);
    chk("r3w_lat", lat, 4);
    chk("r3w_cs_cycles", csc, 3);
    chk("r3w_cs", css, 4'b1000);
    chk("r3w_we_cycles", wec, 3);
    chk("r3w_fault", flt, 1'b0);
    chk("r3w_wdata", s_wdata, 8'h5A);
    chk("r3w_rdata_kept", m_rdata, 8'hA5);

    run(1, 1'b0, 16'h8000, 8'h00, lat, csc, css, wec, flt);
    chk("r2r_lat", lat, 3);
    chk("r2r_cs", css, 4'b0100);
    chk("r2r_rdata", m_rdata, 8'hC2);

    run(0, 1'b0, 16'h4000, 8'h00, lat, csc, css, wec, flt);
    chk("r1r_lat", lat, 2);
    chk("r1r_cs_cycles", csc, 1);
    chk("r1r_rdata", m_rdata, 8'hB1);

    run(1, 1'b0, 16'hFFFF, 8'h00, lat, csc, css, wec, flt);
    chk("ffff_lat", lat, 4);
    chk("ffff_cs", css, 4'b1000);
    chk("ffff_rdata", m_rdata, 8'hD3);

    run(0, 1'b1, 16'h0010, 8'h77, lat, csc, css, wec, flt);
    chk("wp_lat", lat, 2);
    chk("wp_we_cycles", wec, 0);
    chk("wp_fault_with_ack", flt, 1'b1);
    chk("wp_fcnt1", fault_count, 8'd1);
    chk("wp_rdata_kept", m_rdata, 8'hD3);
    for (int i = 0; i < 299; i++) run(0, 1'b1, 16'h0010, 8'h77, lat, csc, css, wec, flt);
    chk("wp_fcnt_sat", fault_count, 8'd255);
    chk("wp_last_lat", lat, 2);

    run(1, 1'b0, 16'h4001, 8'h00, lat, csc, css, wec, flt);
    chk("m1_r1_rdata", m_rdata, 8'hB1);

    m_we = 2'b00;
    m_addr = {16'h8000, 16'h4000};
    m_req = 2'b11;
    for (int k = 0; k < 6; k++) begin
      int w;
      w = 0;
      @(negedge clk);
      while (m_ack == 2'b00 && w < 20) begin @(negedge clk); w++; end
      chk($sformatf("rr_ack%0d", k), m_ack, (k % 2) ? 2'b10 : 2'b01);
      chk($sformatf("rr_rdata%0d", k), m_rdata, (k % 2) ? 8'hC2 : 8'hB1);
      if (k == 5) m_req = 2'b00;
    end
    @(posedge clk); #1;

    m_addr[31:16] = 16'hC000;
    m_we[1] = 1'b0;
    m_req = 2'b10;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_cs_before", s_cs, 4'b1000);
    rst_n = 1'b0;
    #1;
    chk("abort_cs_async", s_cs, 4'b0000);
    chk("abort_we_async", s_we, 1'b0);
    m_req = 2'b00;
    @(posedge clk); #1;
    chk("abort_fcnt", fault_count, 8'd0);
    rst_n = 1'b1;
    wec = 0;
    repeat (4) begin @(negedge clk); if (m_ack != 2'b00) wec++; end
    chk("abort_no_ack", wec, 0);
    @(posedge clk); #1;
    run(1, 1'b0, 16'h8000, 8'h00, lat, csc, css, wec, flt);
    chk("post_abort_lat", lat, 3);
    chk("post_abort_rdata", m_rdata, 8'hC2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
